// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the two-port memory line arbiter.
//   MEM_*       : default widths and watchdog limit
//   arb_state_t : arbiter FSM state encoding
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ADDR_WIDTH     = 32;
  localparam int unsigned MEM_LINE_WIDTH     = 128;
  localparam int unsigned MEM_TIMEOUT_CYCLES = 1024;
  localparam int unsigned MEM_CNT_WIDTH      = 11;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser.
//   req[1:0]   : pending requests (bit 0 = port 0)
//   last_grant : port served most recently
//   gnt_valid  : any request pending
//   gnt_idx    : chosen port; on a tie the port that was not served last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |req;
  assign gnt_idx   = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MainMemory line port between the icache (port 0) and the dcache
// (port 1). Grants are held until mem_ready, priority rotates round-robin, and
// a sticky watchdog flags transactions that wait too long.
//   clk, rst_n                 : clock, async active-low reset
//   s0_* / s1_*                : requester ports (req/we/addr/wdata in, rdata/ready out)
//   mem_req/we/addr/wdata      : to MainMemory, driven from the granted port
//   mem_rdata, mem_ready       : from MainMemory
//   busy                       : grant active
//   err_timeout                : sticky watchdog error
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = MEM_ADDR_WIDTH,
  parameter int unsigned LINE_W         = MEM_LINE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = MEM_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_req,
  input  logic              s0_we,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [LINE_W-1:0] s0_wdata,
  output logic [LINE_W-1:0] s0_rdata,
  output logic              s0_ready,
  input  logic              s1_req,
  input  logic              s1_we,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [LINE_W-1:0] s1_wdata,
  output logic [LINE_W-1:0] s1_rdata,
  output logic              s1_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t        state;
  logic              last_grant;
  logic [CNT_W-1:0]  wd_cnt;
  logic [LINE_W-1:0] rdata0_q;
  logic [LINE_W-1:0] rdata1_q;
  logic              gnt_valid;
  logic              gnt_idx;

  rr_pick2 u_pick (
    .req        ({s1_req, s0_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // FSM, round-robin history, watchdog and returned-line holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      last_grant  <= 1'b1;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            state  <= gnt_idx ? ARB_GRANT1 : ARB_GRANT0;
            wd_cnt <= '0;
          end
        end
        ARB_GRANT0, ARB_GRANT1: begin
          if (mem_ready) begin
            state      <= ARB_IDLE;
            last_grant <= (state == ARB_GRANT1);
            if (state == ARB_GRANT1) rdata1_q <= mem_rdata;
            else                     rdata0_q <= mem_rdata;
          end else if (wd_cnt < WD_MAX) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
            // Grant is kept even after the timeout fires; only the flag is raised
            if (wd_cnt == WD_MAX - CNT_W'(1)) err_timeout <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Memory-side mux and completion path from the granted port
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    s0_rdata  = rdata0_q;
    s1_rdata  = rdata1_q;
    case (state)
      ARB_GRANT0: begin
        mem_req   = s0_req;
        mem_we    = s0_we;
        mem_addr  = s0_addr;
        mem_wdata = s0_wdata;
        s0_ready  = mem_ready;
        if (mem_ready) s0_rdata = mem_rdata;
      end
      ARB_GRANT1: begin
        mem_req   = s1_req;
        mem_we    = s1_we;
        mem_addr  = s1_addr;
        mem_wdata = s1_wdata;
        s1_ready  = mem_ready;
        if (mem_ready) s1_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign busy = (state != ARB_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit MainMemory line port between two cache requesters.
- Port 0 is the instruction cache refill/writeback side; port 1 is the data cache (behind the LSU).
- Grants one requester at a time, holds the grant until memory returns mem_ready, and rotates priority round-robin so neither side starves.
- Sits between the two Cache instances and MainMemory; carries a transaction watchdog.

Parameters:
- ADDR_W, 32, byte address width of the line port
- LINE_W, 128, line data width
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for mem_ready before err_timeout sets
- CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s0_req  in  1  port 0 (icache) request; held high until s0_ready
- s0_we  in  1  port 0 write (line writeback)
- s0_addr  in  ADDR_W  port 0 line address
- s0_wdata  in  LINE_W  port 0 write line
- s0_rdata  out  LINE_W  read line returned to port 0
- s0_ready  out  1  port 0 completion pulse
- s1_req, s1_we, s1_addr, s1_wdata, s1_rdata, s1_ready  same as port 0, for the dcache
- mem_req  out  1  to MainMemory
- mem_we  out  1  to MainMemory
- mem_addr  out  ADDR_W  to MainMemory
- mem_wdata  out  LINE_W  to MainMemory
- mem_rdata  in  LINE_W  from MainMemory
- mem_ready  in  1  from MainMemory; single-cycle completion
- busy  out  1  high while a grant is active
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, last_grant = 1 (so port 0 wins the first tie), watchdog = 0, err_timeout = 0.
  - All mem_* outputs and s*_ready are 0.
  - s*_rdata = 0.
- States:
  - IDLE:
    - Registered grant decision. If exactly one of s0_req/s1_req is high, go to GRANT0/GRANT1 for that port.
    - If both are high, grant the port != last_grant.
    - If neither is high, stay in IDLE.
    - mem_ready in IDLE is ignored.
  - GRANT0 / GRANT1:
    - mem_req/mem_we/mem_addr/mem_wdata are driven combinationally from the granted port; the other port's inputs are ignored.
    - mem_req = granted sX_req.
    - On mem_ready: sX_ready = mem_ready (combinational, granted port only); sX_rdata = mem_rdata.
    - On that same edge, last_grant <= X and state <= IDLE.
    - The non-granted sY_ready is always 0; sY_rdata holds its previous value.
- Grant stability:
  - The grant is never revoked before mem_ready, even if the granted requester drops req mid-transaction. In that case mem_req falls and the state still waits for mem_ready.
- Latency:
  - A request first seen in IDLE at edge N drives mem_req from cycle N+1.
  - After completion there is one mandatory IDLE cycle. Minimum spacing between two transactions is (memory latency + 1) cycles.
- busy = (state != IDLE).
- Watchdog:
  - Cleared on entry to GRANTx.
  - Increments each cycle in GRANTx without mem_ready, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES, err_timeout <= 1 and stays set until rst_n. The grant is still held; no forced release.
- Simultaneous events:
  - A new request arriving in the same cycle as mem_ready is not granted until the following IDLE cycle.
  - Both requests arriving together in IDLE are resolved by last_grant.
- Reset mid-transaction:
  - Immediate return to IDLE with outputs at reset values.
  - Requesters are reset by the same rst_n, so no replay is needed.
- No flush input: a memory line transaction always runs to completion. Pipeline flush is handled inside the LSU/fetch unit.

Decomposition:
- Shared constants go in riscv_define.v:
  - MEM_LINE_WIDTH (128)
  - arbiter state encodings ARB_IDLE / ARB_GRANT0 / ARB_GRANT1
  - default MEM_TIMEOUT_CYCLES
- One natural sub-module: rr_pick2. It is a combinational 2-way round-robin chooser: inputs req[1:0] and last_grant; outputs gnt_valid and gnt_idx.
- The FSM, muxing and watchdog stay in mem_port_arbiter.

Test Plan:
- Single read: s1_req with s1_addr=0x0000_1040, s1_we=0; memory returns 0xDEADBEEF_...(128b) after 3 cycles.
  - Expect mem_req high from cycle 1, mem_addr=0x1040, s1_ready pulse with s1_rdata equal to that line, s0_ready stays 0, busy falls the cycle after ready.
- Tie: s0_req and s1_req both high from reset.
  - Expect port 0 served first, then port 1 after one IDLE cycle, then port 0 again if both remain requesting (strict alternation over 6 transactions).
- Write: s0_we=1, s0_addr=0x2000, s0_wdata=128'h0123_4567_89AB_CDEF_0011_2233_4455_6677.
  - Expect mem_we=1, mem_wdata equal to that value throughout the grant; s1 inputs toggled randomly have no effect on mem_*.
- Request drop mid-grant: s1_req falls 1 cycle after grant; mem_ready arrives 4 cycles later.
  - Expect mem_req=0 but busy=1 until ready, then s1_ready pulse and return to IDLE.
- Timeout: TIMEOUT_CYCLES=16, memory never asserts mem_ready.
  - Expect err_timeout to rise exactly 16 cycles after grant, stay high, and busy stay high.
  - Then apply rst_n=0 mid-grant: expect all outputs 0 and err_timeout cleared immediately.
